// File: rtl/dct_pkg.sv
// dct_pkg: lifting constants, default widths and output lane order shared by the DCT row pipe
package dct_pkg;
  localparam int IN_W_DEF = 11;
  localparam int FRAC_DEF = 4;
  localparam int OUT_W_DEF = 14;
  localparam int K38_M = 3;
  localparam int K38_S = 3;
  localparam int K58_M = 5;
  localparam int K58_S = 3;
  localparam int K78_M = 7;
  localparam int K78_S = 3;
  localparam int K18_S = 3;
  localparam int K12_S = 1;
  localparam int PERM [8] = '{0, 7, 3, 6, 1, 5, 2, 4};
endpackage

// File: rtl/dct_round_sat.sv
// dct_round_sat: round half up by FRAC bits, then clip to OUT_W signed with a clip flag
module dct_round_sat #(
  parameter int FRAC = 4,
  parameter int INT_W = 19,
  parameter int OUT_W = 14
) (
  input  logic signed [INT_W-1:0] e_i,
  output logic signed [OUT_W-1:0] y_o,
  output logic                    sat_o
);
  localparam int QW = INT_W - FRAC + 1;
  localparam logic signed [QW-1:0] MAXV = QW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [QW-1:0] MINV = -MAXV - QW'(1);
  logic signed [INT_W:0] sum;
  logic signed [QW-1:0] q;
  logic hi, lo;
  assign sum = (INT_W+1)'(e_i) + (INT_W+1)'(2 ** (FRAC - 1));
  assign q = QW'(sum >>> FRAC);
  assign hi = q > MAXV;
  assign lo = q < MINV;
  assign y_o = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : q[OUT_W-1:0];
  assign sat_o = hi | lo;
endmodule

// File: rtl/dct8_row_pipe.sv
// dct8_row_pipe: five-stage lifting 8-point DCT on one row per cycle, global-enable valid/ready stall
module dct8_row_pipe
  import dct_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int INT_W = IN_W + FRAC + 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [IN_W-1:0]  i_data0,
  input  logic signed [IN_W-1:0]  i_data1,
  input  logic signed [IN_W-1:0]  i_data2,
  input  logic signed [IN_W-1:0]  i_data3,
  input  logic signed [IN_W-1:0]  i_data4,
  input  logic signed [IN_W-1:0]  i_data5,
  input  logic signed [IN_W-1:0]  i_data6,
  input  logic signed [IN_W-1:0]  i_data7,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [OUT_W-1:0] o_data0,
  output logic signed [OUT_W-1:0] o_data1,
  output logic signed [OUT_W-1:0] o_data2,
  output logic signed [OUT_W-1:0] o_data3,
  output logic signed [OUT_W-1:0] o_data4,
  output logic signed [OUT_W-1:0] o_data5,
  output logic signed [OUT_W-1:0] o_data6,
  output logic signed [OUT_W-1:0] o_data7,
  output logic                    o_sat
);
  typedef logic signed [INT_W-1:0] w_t;
  localparam int PW = INT_W + 3;
  // constant multiply by 3/5/7 as shift-add, kept 3 bits wider so the product cannot wrap before the shift
  function automatic w_t kmul(input w_t x, input int m, input int s);
    logic signed [PW-1:0] xw, p;
    xw = PW'(x);
    p = (m == 7) ? (xw <<< 3) - xw : (m == 5) ? (xw <<< 2) + xw : (xw <<< 1) + xw;
    return w_t'(p >>> s);
  endfunction
  w_t x [8];
  w_t a_d [8], a_q [8], b_d [8], b_q [8], c_d [8], c_q [8], d_d [8], d_q [8], e [8];
  logic signed [OUT_W-1:0] y_rs [8], y_q [8];
  logic [7:0] sat_rs;
  logic [3:0] v_q;
  logic o_valid_q, sat_q, en;
  assign en = !o_valid_q || i_ready;
  assign o_ready = en;
  assign x[0] = w_t'(i_data0);
  assign x[1] = w_t'(i_data1);
  assign x[2] = w_t'(i_data2);
  assign x[3] = w_t'(i_data3);
  assign x[4] = w_t'(i_data4);
  assign x[5] = w_t'(i_data5);
  assign x[6] = w_t'(i_data6);
  assign x[7] = w_t'(i_data7);
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_d[i] = x[i] + x[7-i];
      a_d[7-i] = x[i] - x[7-i];
    end
    b_d[0] = (a_q[0] + a_q[3]) <<< FRAC;
    b_d[1] = (a_q[1] + a_q[2]) <<< FRAC;
    b_d[2] = (a_q[1] - a_q[2]) <<< FRAC;
    b_d[3] = (a_q[0] - a_q[3]) <<< FRAC;
    b_d[4] = a_q[4] <<< FRAC;
    b_d[5] = a_q[5] <<< FRAC;
    b_d[6] = (a_q[6] <<< FRAC) + kmul(a_q[5] <<< FRAC, K38_M, K38_S);
    b_d[7] = a_q[7] <<< FRAC;
    c_d[0] = b_q[0] + b_q[1];
    c_d[1] = b_q[1];
    c_d[2] = b_q[2] - kmul(b_q[3], K38_M, K38_S);
    c_d[3] = b_q[3];
    c_d[4] = b_q[4];
    c_d[5] = kmul(b_q[6], K58_M, K58_S) - b_q[5];
    c_d[6] = b_q[7] - b_q[6];
    c_d[7] = b_q[6] + b_q[7];
    d_d = c_q;
    d_d[1] = (c_q[0] >>> K12_S) - c_q[1];
    d_d[3] = c_q[3] + kmul(c_q[2], K38_M, K38_S);
    d_d[4] = c_q[4] + c_q[5] - (c_q[7] >>> K18_S);
    d_d[5] = c_q[4] - c_q[5] + kmul(c_q[6], K78_M, K78_S);
    e = d_q;
    e[6] = d_q[6] - (d_q[5] >>> K12_S);
  end
  for (genvar k = 0; k < 8; k++) begin : g_rs
    dct_round_sat #(.FRAC(FRAC), .INT_W(INT_W), .OUT_W(OUT_W)) u_rs (
      .e_i(e[k]), .y_o(y_rs[k]), .sat_o(sat_rs[k])
    );
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q <= '0;
      o_valid_q <= 1'b0;
      sat_q <= 1'b0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      c_q <= '{default: '0};
      d_q <= '{default: '0};
      y_q <= '{default: '0};
    end else if (en) begin
      v_q <= {v_q[2:0], i_valid};
      o_valid_q <= v_q[3];
      sat_q <= v_q[3] && |sat_rs;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
      for (int j = 0; j < 8; j++) y_q[j] <= y_rs[PERM[j]];
    end
  end
  assign o_valid = o_valid_q;
  assign o_sat = sat_q;
  assign o_data0 = y_q[0];
  assign o_data1 = y_q[1];
  assign o_data2 = y_q[2];
  assign o_data3 = y_q[3];
  assign o_data4 = y_q[4];
  assign o_data5 = y_q[5];
  assign o_data6 = y_q[6];
  assign o_data7 = y_q[7];
endmodule

// File: tb/tb_dct8_row_pipe.sv
// tb_dct8_row_pipe: scoreboard bench driving OUT_W=14 and OUT_W=12 instances with identical rows
module tb_dct8_row_pipe;
  localparam int F = 4;
  typedef struct packed { logic sat; logic [7:0][63:0] y; } exp_t;
  logic clk = 0, rst = 1, i_valid = 0, i_ready = 1;
  int xr [8];
  logic signed [10:0] xd [8];
  logic signed [13:0] y14 [8];
  logic signed [11:0] y12 [8];
  logic rdy14, rdy12, v14, v12, s14, s12;
  exp_t q14 [$], q12 [$];
  int n_vec = 0, n_err = 0;
  logic hold_v = 0;
  logic [111:0] hold_d = '0;
  wire [111:0] cat14 = {y14[7], y14[6], y14[5], y14[4], y14[3], y14[2], y14[1], y14[0]};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 8; g++) begin : g_x
    assign xd[g] = 11'(xr[g]);
  end
  dct8_row_pipe dut14 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy14),
    .i_data0(xd[0]), .i_data1(xd[1]), .i_data2(xd[2]), .i_data3(xd[3]),
    .i_data4(xd[4]), .i_data5(xd[5]), .i_data6(xd[6]), .i_data7(xd[7]),
    .o_valid(v14), .i_ready(i_ready),
    .o_data0(y14[0]), .o_data1(y14[1]), .o_data2(y14[2]), .o_data3(y14[3]),
    .o_data4(y14[4]), .o_data5(y14[5]), .o_data6(y14[6]), .o_data7(y14[7]),
    .o_sat(s14)
  );
  dct8_row_pipe #(.OUT_W(12)) dut12 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy12),
    .i_data0(xd[0]), .i_data1(xd[1]), .i_data2(xd[2]), .i_data3(xd[3]),
    .i_data4(xd[4]), .i_data5(xd[5]), .i_data6(xd[6]), .i_data7(xd[7]),
    .o_valid(v12), .i_ready(i_ready),
    .o_data0(y12[0]), .o_data1(y12[1]), .o_data2(y12[2]), .o_data3(y12[3]),
    .o_data4(y12[4]), .o_data5(y12[5]), .o_data6(y12[6]), .o_data7(y12[7]),
    .o_sat(s12)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input int x [8], input int ow);
    longint a [8], b [8], c [8], d [8], e [8], r, mx;
    int p [8] = '{0, 7, 3, 6, 1, 5, 2, 4};
    exp_t t = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = x[i] + x[7-i];
      a[7-i] = x[i] - x[7-i];
    end
    b[0] = (a[0] + a[3]) <<< F;
    b[1] = (a[1] + a[2]) <<< F;
    b[2] = (a[1] - a[2]) <<< F;
    b[3] = (a[0] - a[3]) <<< F;
    b[4] = a[4] <<< F;
    b[5] = a[5] <<< F;
    b[6] = (a[6] <<< F) + (((3 * a[5]) <<< F) >>> 3);
    b[7] = a[7] <<< F;
    c[0] = b[0] + b[1];
    c[1] = b[1];
    c[2] = b[2] - ((3 * b[3]) >>> 3);
    c[3] = b[3];
    c[4] = b[4];
    c[5] = ((5 * b[6]) >>> 3) - b[5];
    c[6] = b[7] - b[6];
    c[7] = b[6] + b[7];
    d = c;
    d[1] = (c[0] >>> 1) - c[1];
    d[3] = c[3] + ((3 * c[2]) >>> 3);
    d[4] = c[4] + c[5] - (c[7] >>> 3);
    d[5] = c[4] - c[5] + ((7 * c[6]) >>> 3);
    e = d;
    e[6] = d[6] - (d[5] >>> 1);
    mx = (longint'(1) <<< (ow - 1)) - 1;
    for (int j = 0; j < 8; j++) begin
      r = (e[p[j]] + (longint'(1) <<< (F - 1))) >>> F;
      if (r > mx) begin
        r = mx;
        t.sat = 1'b1;
      end else if (r < -mx - 1) begin
        r = -mx - 1;
        t.sat = 1'b1;
      end
      t.y[j] = r;
    end
    return t;
  endfunction
  always @(negedge clk) begin
    exp_t e14, e12;
    if (rst) begin
      q14.delete();
      q12.delete();
      hold_v = 1'b0;
    end else begin
      if (i_valid && rdy14) begin
        q14.push_back(model(xr, 14));
        q12.push_back(model(xr, 12));
      end
      if (hold_v) begin
        chk("stall_valid", v14, 1);
        chk("stall_data", cat14 == hold_d, 1);
      end
      if (v14 && i_ready) begin
        chk("v12_rdy12", {v12, rdy12}, {v14, rdy14});
        if (q14.size() == 0) chk("extra_row", 1, 0);
        else begin
          e14 = q14.pop_front();
          e12 = q12.pop_front();
          for (int j = 0; j < 8; j++) begin
            chk($sformatf("y14[%0d]", j), y14[j], $signed(e14.y[j]));
            chk($sformatf("y12[%0d]", j), y12[j], $signed(e12.y[j]));
          end
          chk("sat14", s14, e14.sat);
          chk("sat12", s12, e12.sat);
        end
      end
      hold_v = v14 && !i_ready;
      hold_d = cat14;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_row(input int v);
    for (int i = 0; i < 8; i++) xr[i] = v;
  endtask
  task automatic set_rand;
    for (int i = 0; i < 8; i++) xr[i] = int'($urandom_range(0, 2047)) - 1024;
  endtask
  task automatic one_row(input int v, input longint e14, input longint e12, input logic es14, input logic es12);
    int lat = 1;
    set_row(v);
    i_valid = 1;
    i_ready = 1;
    tick;
    i_valid = 0;
    while (!v14 && lat < 20) begin
      tick;
      lat++;
    end
    chk("latency", lat, 5);
    chk("y0_w14", y14[0], e14);
    chk("y0_w12", y12[0], e12);
    chk("osat_w14", s14, es14);
    chk("osat_w12", s12, es12);
    for (int j = 1; j < 8; j++) chk($sformatf("zero_y14[%0d]", j), y14[j], 0);
  endtask
  initial begin
    int sent, guard, acc_n, cnt;
    logic acc;
    tick;
    chk("rst_valid", v14, 0);
    chk("rst_sat", s14, 0);
    chk("rst_y0", y14[0], 0);
    rst = 0;
    tick;
    chk("post_rst_ready", rdy14, 1);
    chk("post_rst_valid", v14, 0);
    one_row(100, 800, 800, 0, 0);
    one_row(-100, -800, -800, 0, 0);
    one_row(0, 0, 0, 0, 0);
    one_row(1023, 8184, 2047, 0, 1);
    one_row(-1024, -8192, -2048, 0, 1);
    sent = 0;
    guard = 0;
    set_rand;
    i_valid = 1;
    while (sent < 16 && guard < 400) begin
      i_ready = $urandom_range(0, 1) == 1;
      @(negedge clk);
      acc = rdy14;
      tick;
      guard++;
      if (acc) begin
        sent++;
        set_rand;
      end
    end
    chk("rand_sent", sent, 16);
    i_valid = 0;
    i_ready = 1;
    repeat (10) tick;
    i_ready = 0;
    i_valid = 1;
    acc_n = 0;
    repeat (8) begin
      set_rand;
      @(negedge clk);
      if (rdy14) acc_n++;
      tick;
    end
    chk("stall_accepted", acc_n, 5);
    chk("stall_ready", rdy14, 0);
    i_valid = 0;
    i_ready = 1;
    repeat (5) begin
      @(negedge clk);
      chk("drain_valid", v14, 1);
    end
    @(negedge clk);
    chk("drain_done", v14, 0);
    tick;
    i_valid = 1;
    repeat (3) begin
      set_rand;
      tick;
    end
    i_valid = 0;
    rst = 1;
    tick;
    rst = 0;
    chk("midrst_valid", v14, 0);
    chk("midrst_ready", rdy14, 1);
    cnt = 0;
    repeat (10) begin
      tick;
      cnt += int'(v14);
    end
    chk("no_stale_rows", cnt, 0);
    chk("scoreboard_empty", q14.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
